// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one result bit per clock, registered sum/cout/done/busy.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             sum_bit_d;
    logic             carry_d;

    assign sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_d   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    psum_q  <= {sum_bit_d, psum_q[WIDTH-1:1]};
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    // The last shift lands bit 0 of the result in psum_q[0].
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    sum_q   <= psum_q;
                    cout_q  <= carry_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder with directed and random additions.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } op_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    op_t  ops[$];
    exp_t expq[$];
    int   cyc;
    int   checks;
    int   errors;
    logic [W-1:0] last_sum;
    logic         last_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input op_t o, input int acc_cyc);
        exp_t     e;
        logic [W:0] t;
        t = {1'b0, o.a} + {1'b0, o.b} + {{W{1'b0}}, o.cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.cyc  = acc_cyc + W + 1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Done cycles are stamped with the posedge count seen at the sampling negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_sum  = '0;
            last_cout = 1'b0;
        end else if (done) begin
            if (expq.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("done_latency", 32'(cyc), 32'(e.cyc));
            end
            last_sum  = sum;
            last_cout = cout;
        end else begin
            check("hold_sum", 32'(sum), 32'(last_sum));
            check("hold_cout", 32'(cout), 32'(last_cout));
        end
    end

    task automatic add_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
        op_t o;
        o.a = oa;
        o.b = ob;
        o.cin = oc;
        ops.push_back(o);
    endtask

    // Keeps start high while queued ops remain, loading the next op whenever the DUT is idle.
    task automatic drive_ops();
        op_t o;
        int  guard;
        while (ops.size() > 0) begin
            @(negedge clk);
            guard = 0;
            while (busy && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (busy) begin
                check("drive_timeout", 32'(busy), 32'(0));
                ops.delete();
            end else begin
                o = ops.pop_front();
                a = o.a;
                b = o.b;
                cin = o.cin;
                start = 1'b1;
                expq.push_back(model(o, cyc + 1));
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (expq.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(expq.size()), 32'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_sum = '0;
        last_cout = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;

        add_op(8'h00, 8'h00, 1'b0);
        add_op(8'hFF, 8'h01, 1'b0);
        add_op(8'hFF, 8'hFF, 1'b1);
        add_op(8'h5A, 8'hA5, 1'b0);
        drive_ops();
        wait_drain();

        // Start pulsed during busy must not be sampled.
        add_op(8'h10, 8'h20, 1'b0);
        drive_ops();
        @(negedge clk);
        check("busy_mid_op", 32'(busy), 32'(1));
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        // Reset four cycles into 7F+01 aborts with no done and clears outputs at once.
        add_op(8'h7F, 8'h01, 1'b0);
        drive_ops();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        expq.delete();
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_sum", 32'(sum), 32'(0));
        check("abort_cout", 32'(cout), 32'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        add_op(8'h7F, 8'h01, 1'b0);
        drive_ops();
        wait_drain();

        // Start held high across two requests: done pulses W+2 cycles apart.
        add_op(8'h01, 8'h02, 1'b0);
        add_op(8'h80, 8'h80, 1'b0);
        drive_ops();
        wait_drain();

        for (int i = 0; i < 30; i++) begin
            add_op(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                add_op(W'($urandom), W'($urandom), 1'($urandom));
            end
            drive_ops();
            if ($urandom_range(0, 1) == 0) begin
                wait_drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_drain();
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
